div_arb: RTL and testbench

Two-port round-robin arbiter and sequencer that shares one `div_top` combinational divider instance between two requesters. It latches the granted requester's operands and holds them stable for a programmable number of settle cycles. It then captures quotient, remainder and overflow into output registers and signals completion tagged with the requester ID. It sits between the two operand sources and the single divider datapath, so the divider's long combinational path is exercised as a multicycle path.

---
 rtl/div_arb.sv | 158 +++++++++++++++
 tb/tb_div_arb.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/div_arb.sv
// Round-robin arbiter that shares one combinational divider between two
// requesters and holds the latched operands for calc_cycles before capturing.

module div_top #(
  parameter int width = 6
) (
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  output logic [width-1:0] q,
  output logic [width-1:0] r,
  output logic             ovf
);
  always_comb begin
    if (b == '0) begin
      q   = '1;
      r   = a;
      ovf = 1'b1;
    end else begin
      q   = a / b;
      r   = a % b;
      ovf = 1'b0;
    end
  end
endmodule

module div_arb #(
  parameter int width       = 6,
  parameter int calc_cycles = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [width-1:0] a0,
  input  logic [width-1:0] b0,
  input  logic             req1,
  input  logic [width-1:0] a1,
  input  logic [width-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic [width-1:0] q,
  output logic [width-1:0] r,
  output logic             ovf
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(calc_cycles - 1);

  state_t           state_q, state_d;
  logic             last_q, last_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [width-1:0] opa_q, opa_d, opb_q, opb_d;
  logic [width-1:0] q_q, q_d, r_q, r_d;
  logic             ovf_q, ovf_d, done_id_q, done_id_d;
  logic             gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic             busy_q, busy_d, done_q, done_d;

  logic [width-1:0] div_q, div_r;
  logic             div_ovf;
  logic             win;

  div_top #(.width(width)) u_div (
    .a   (opa_q),
    .b   (opb_q),
    .q   (div_q),
    .r   (div_r),
    .ovf (div_ovf)
  );

  // On a tie the requester that did not win last time is served.
  assign win = (req0 && req1) ? ~last_q : req1;

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    q_d       = q_q;
    r_d       = r_q;
    ovf_d     = ovf_q;
    done_id_d = done_id_q;
    gnt0_d    = 1'b0;
    gnt1_d    = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          state_d = CALC;
          opa_d   = win ? a1 : a0;
          opb_d   = win ? b1 : b0;
          gnt0_d  = ~win;
          gnt1_d  = win;
          last_d  = win;
          cnt_d   = CNT_LOAD;
        end
      end
      CALC: begin
        if (cnt_q == '0) begin
          q_d       = div_q;
          r_d       = div_r;
          ovf_d     = div_ovf;
          done_id_d = last_q;
          done_d    = 1'b1;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      cnt_q     <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      q_q       <= '0;
      r_q       <= '0;
      ovf_q     <= 1'b0;
      done_id_q <= 1'b0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      q_q       <= q_d;
      r_q       <= r_d;
      ovf_q     <= ovf_d;
      done_id_q <= done_id_d;
      gnt0_q    <= gnt0_d;
      gnt1_q    <= gnt1_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign gnt0    = gnt0_q;
  assign gnt1    = gnt1_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign done_id = done_id_q;
  assign q       = q_q;
  assign r       = r_q;
  assign ovf     = ovf_q;
endmodule

// File: tb/tb_div_arb.sv
// Bench for div_arb: two instances (calc_cycles 2 and 1) share stimulus and are
// compared every cycle against an operation-level model of the arbiter.

module tb_div_arb;
  localparam int W = 6;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0 = 1'b0, req1 = 1'b0;
  logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;

  logic         gnt0_o [2];
  logic         gnt1_o [2];
  logic         busy_o [2];
  logic         done_o [2];
  logic         id_o   [2];
  logic [W-1:0] q_o    [2];
  logic [W-1:0] r_o    [2];
  logic         ovf_o  [2];

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;
  int n_edge   = 0;

  always #5 clk = ~clk;

  div_arb #(.width(W), .calc_cycles(2)) dut0 (
    .clk(clk), .rst(rst),
    .req0(req0), .a0(a0), .b0(b0), .req1(req1), .a1(a1), .b1(b1),
    .gnt0(gnt0_o[0]), .gnt1(gnt1_o[0]), .busy(busy_o[0]), .done(done_o[0]),
    .done_id(id_o[0]), .q(q_o[0]), .r(r_o[0]), .ovf(ovf_o[0])
  );

  div_arb #(.width(W), .calc_cycles(1)) dut1 (
    .clk(clk), .rst(rst),
    .req0(req0), .a0(a0), .b0(b0), .req1(req1), .a1(a1), .b1(b1),
    .gnt0(gnt0_o[1]), .gnt1(gnt1_o[1]), .busy(busy_o[1]), .done(done_o[1]),
    .done_id(id_o[1]), .q(q_o[1]), .r(r_o[1]), .ovf(ovf_o[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Model: an operation started at edge E0 owns the unit through edge E0+calc+1.
  bit           m_act  [2];
  int           m_e0   [2];
  bit           m_last [2];
  int           m_a    [2];
  int           m_b    [2];
  bit           e_gnt0 [2], e_gnt1 [2], e_busy [2], e_done [2], e_id [2], e_ovf [2];
  int           e_q    [2], e_r    [2];

  task automatic model_step(input int i, input int calc);
    bit w;
    e_gnt0[i] = 0;
    e_gnt1[i] = 0;
    e_done[i] = 0;
    if (rst) begin
      m_act[i] = 0; m_last[i] = 1;
      e_id[i] = 0; e_q[i] = 0; e_r[i] = 0; e_ovf[i] = 0;
    end else if (!m_act[i]) begin
      if (req0 || req1) begin
        w = (req0 && req1) ? !m_last[i] : req1;
        m_last[i] = w;
        m_a[i] = w ? int'(a1) : int'(a0);
        m_b[i] = w ? int'(b1) : int'(b0);
        m_act[i] = 1; m_e0[i] = n_edge;
        e_gnt0[i] = !w; e_gnt1[i] = w;
      end
    end else if (n_edge == m_e0[i] + calc) begin
      e_done[i] = 1;
      e_id[i]   = m_last[i];
      if (m_b[i] == 0) begin
        e_q[i] = (1 << W) - 1; e_r[i] = m_a[i]; e_ovf[i] = 1;
      end else begin
        e_q[i] = m_a[i] / m_b[i]; e_r[i] = m_a[i] % m_b[i]; e_ovf[i] = 0;
      end
    end else if (n_edge == m_e0[i] + calc + 1) begin
      m_act[i] = 0;
    end
    e_busy[i] = m_act[i];
  endtask

  always @(posedge clk) begin
    n_edge++;
    model_step(0, 2);
    model_step(1, 1);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("gnt0[%0d]", i), gnt0_o[i], e_gnt0[i]);
        check($sformatf("gnt1[%0d]", i), gnt1_o[i], e_gnt1[i]);
        check($sformatf("busy[%0d]", i), busy_o[i], e_busy[i]);
        check($sformatf("done[%0d]", i), done_o[i], e_done[i]);
        check($sformatf("done_id[%0d]", i), id_o[i], e_id[i]);
        check($sformatf("q[%0d]", i), q_o[i], e_q[i]);
        check($sformatf("r[%0d]", i), r_o[i], e_r[i]);
        check($sformatf("ovf[%0d]", i), ovf_o[i], e_ovf[i]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic idle_wait(input int n);
    req0 = 1'b0; req1 = 1'b0;
    repeat (n) step();
  endtask

  int g_edge [$];
  int g_id   [$];

  initial begin
    do_reset();
    chk_en = 1'b1;
    check("rst_busy", busy_o[0], 0);
    check("rst_q", q_o[0], 0);

    // Single request, 45 / 7.
    req0 = 1; a0 = 45; b0 = 7;
    step();                       // E0 sampled
    req0 = 0;
    check("single_gnt0", gnt0_o[0], 1);
    step();                       // E0+1
    check("single_done_c1", done_o[1], 1);
    check("single_q_c1", q_o[1], 6);
    step();                       // E0+2
    check("single_done", done_o[0], 1);
    check("single_q", q_o[0], 6);
    check("single_r", r_o[0], 3);
    check("single_id", id_o[0], 0);
    step();
    check("single_done_once", done_o[0], 0);
    idle_wait(3);

    // Held tie after reset: alternating grants every 4 cycles.
    do_reset();
    req0 = 1; a0 = 63; b0 = 1;
    req1 = 1; a1 = 5;  b1 = 9;
    repeat (20) begin
      step();
      if (gnt0_o[0] || gnt1_o[0]) begin
        g_edge.push_back(n_edge);
        g_id.push_back(gnt1_o[0] ? 1 : 0);
      end
    end
    idle_wait(5);
    check("tie_ngrants", (g_edge.size() >= 4) ? 1 : 0, 1);
    if (g_id.size() > 0) check("tie_first", g_id[0], 0);
    for (int k = 1; k < g_edge.size(); k++) begin
      check("tie_spacing", g_edge[k] - g_edge[k-1], 4);
      check("tie_alt", g_id[k], 1 - g_id[k-1]);
    end

    // Divide by zero, then a normal division clears ovf.
    req1 = 1; a1 = 20; b1 = 0;
    step(); req1 = 0;
    step(); step();
    check("dz_ovf", ovf_o[0], 1);
    check("dz_q", q_o[0], 63);
    check("dz_r", r_o[0], 20);
    check("dz_id", id_o[0], 1);
    idle_wait(2);
    req0 = 1; a0 = 9; b0 = 4;
    step(); req0 = 0;
    step(); step();
    check("dz_clear", ovf_o[0], 0);
    idle_wait(2);

    // Operand stability: a0/b0 churn after the grant edge.
    req0 = 1; a0 = 50; b0 = 6;
    step(); req0 = 0;
    a0 = W'($urandom); b0 = W'($urandom);
    step();
    a0 = W'($urandom); b0 = W'($urandom);
    step();
    check("stab_q", q_o[0], 8);
    check("stab_r", r_o[0], 2);
    a0 = W'($urandom); b0 = W'($urandom);
    idle_wait(3);

    // Reset during CALC, then a tie must go to requester 0.
    req0 = 1; a0 = 30; b0 = 4;
    step(); req0 = 0;
    step();
    rst = 1;
    step();
    rst = 0;
    check("rstmid_done", done_o[0], 0);
    check("rstmid_q", q_o[0], 0);
    req0 = 1; req1 = 1;
    step(); req0 = 0; req1 = 0;
    check("rstmid_gnt0", gnt0_o[0], 1);
    idle_wait(4);

    // Request 1 pulsed only while busy is never granted.
    req0 = 1; a0 = 12; b0 = 5;
    step(); req0 = 0;
    req1 = 1; a1 = 7; b1 = 2;
    step();
    req1 = 0;
    check("withdraw_gnt1", gnt1_o[0], 0);
    idle_wait(5);

    // Randomized traffic with occasional reset.
    repeat (600) begin
      req0 = ($urandom_range(0, 3) != 0);
      req1 = ($urandom_range(0, 2) == 0);
      a0 = W'($urandom); b0 = W'($urandom_range(0, 7));
      a1 = W'($urandom); b1 = W'($urandom);
      rst = ($urandom_range(0, 79) == 0);
      step();
    end
    rst = 0;
    idle_wait(6);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
